cast_input_buffer: RTL and testbench
====================================

# cast_input_buffer

Per-VC input buffering stage of a NoC router port, sitting directly downstream of `cast_output_arbitration` on the link. It accepts one flit per cycle tagged with a one-hot VC vector and steers it into one of `VN` independent FIFOs. It presents each FIFO head to the router core as a separate valid/ready stream. Flow control is per VC: link `ready_o` reflects only the free space of the VC the incoming flit is tagged for.

## Interface
Parameters:
- `DW`, default `` `DW ``: flit width in bits.
- `VN`, default `` `VN ``: number of virtual channels (≥2).
- `DEPTH`, default 4: entries per VC FIFO; power of two, ≥2.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `vc_i`  in  VN  one-hot VC tag of the incoming flit.
- `data_i`  in  DW  incoming flit.
- `valid_i`  in  1  incoming flit valid.
- `ready_o`  out  1  link ready; combinational from `vc_i` and FIFO full flags.
- `data_o [VN]`  out  DW each  head flit of each VC FIFO.
- `valid_o [VN]`  out  1 each  VC FIFO non-empty.
- `ready_i [VN]`  in  1 each  router core pops the VC head.
- `count_o [VN]`  out  $clog2(DEPTH)+1 each  current occupancy of each VC FIFO, 0..DEPTH.
- `err_o`  out  1  sticky: `valid_i` seen with non-one-hot `vc_i`.

## Operation
- Each VC has a circular FIFO:
  - write and read pointers of $clog2(DEPTH)+1 bits; the MSB is the wrap bit.
  - empty = pointers equal; full = index bits equal and wrap bits differ.
- `ready_o` = `vc_i` is one-hot AND the selected VC is not full.
  - `ready_o` is independent of `valid_i` and of all `ready_i`; there is no full-bypass.
  - A full VC deasserts `ready_o` even if it is popped in the same cycle.
- Push condition: `valid_i & ready_o`.
  - Write `data_i` at the selected VC's write pointer and increment it.
  - Other VCs are unaffected.
- Pop on VC v: `valid_o[v] & ready_i[v]`; increment v's read pointer.
  - Pops on different VCs are independent and may all occur in the same cycle.
- Push and pop on the same VC in one cycle: both take effect and `count_o[v]` is unchanged. This is legal only when not full; when the VC is empty, no pop can occur.
- `data_o[v]` = entry at v's read pointer (show-ahead). It is undefined, but must not be X-propagating into `valid_o`, when empty.
- `valid_o[v]` = not empty.
- `count_o[v]` = write pointer − read pointer, modulo 2·DEPTH.
- Non-one-hot `vc_i` (zero or multi-hot):
  - `ready_o` = 0 and no push occurs.
  - If `valid_i` = 1 in that cycle, `err_o` sets and stays set until `rst`.
- Pointer wrap is natural modulo 2·DEPTH; no special-casing.

## Timing
- Reset values, with `rst` high at an edge:
  - all pointers 0, so all `valid_o` = 0 and all `count_o` = 0;
  - `err_o` = 0;
  - `ready_o` = 1 whenever `vc_i` is one-hot;
  - storage contents are not reset.
- Reset mid-operation discards all buffered flits in the same edge. A push or pop coinciding with `rst` is ignored.
- Latency: a flit pushed at edge N shows `valid_o[v]` = 1 and `data_o[v]` = flit after edge N (cycle N+1). There is no same-cycle pass-through.
- Throughput: one push per cycle across the link; one pop per cycle per VC.
- Timing paths:
  - `ready_o` is a combinational path from `vc_i`; the upstream `vc_o` is grant-derived and does not depend on `ready_o`, so no loop exists.
  - `valid_o`, `data_o`, `count_o` and `err_o` are registered or decoded from registers only.
- Upstream ready/valid rule: the flit transfers on any edge where `valid_i` and `ready_o` are both high. The holder keeps data stable while `ready_o` is low.

## Test plan
- Reset then idle: `rst` for 2 cycles → all `valid_o` = 0, `count_o` = 0, `err_o` = 0; with `vc_i`=01, `ready_o` = 1.
- Fill VC0 (VN=2, DEPTH=4): push 0xA0..0xA3 on `vc_i`=01 with `ready_i[0]`=0 → `count_o[0]` goes 1,2,3,4, then `ready_o` = 0 for `vc_i`=01 while it is 1 for `vc_i`=10. A fifth flit is held, not written. Drain → heads 0xA0..0xA3 in order.
- Full with simultaneous pop: VC0 full, `ready_i[0]`=1, `valid_i`=1 → one pop, no push, `count_o[0]`=3. The next cycle the push is accepted and the count stays 3 with concurrent pop.
- Interleaved VCs with wrap: 20 pushes alternating `vc_i`=01/10 with data = index, and random `ready_i` → each VC outputs its own subsequence in order. Pointers wrap at least twice with no loss or duplication.
- Bad tag: `valid_i`=1 and `vc_i`=11 → `ready_o`=0, no count change, `err_o`=1 from the next cycle. Afterwards, `vc_i`=00 with `valid_i`=0 → `err_o` stays 1 until `rst`.
- Reset mid-stream: VC1 holds 3 flits; assert `rst` together with a push → after the edge `count_o[1]`=0, `valid_o[1]`=0, and the pushed flit is not present.

Source files
------------

// File: rtl/cast_input_buffer.sv
// cast_input_buffer: per-VC input buffering for one NoC router port.
// Incoming flits carry a one-hot VC tag and are steered into one of VN
// circular FIFOs. Each FIFO head is exposed as an independent show-ahead
// valid/ready stream to the router core. Link ready reflects only the
// free space of the VC the current flit is tagged for.

`ifndef DW
`define DW 32
`endif
`ifndef VN
`define VN 2
`endif

module cast_input_buffer #(
   parameter int DW    = `DW,
   parameter int VN    = `VN,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [VN-1:0]              vc_i,
   input  logic [DW-1:0]              data_i,
   input  logic                       valid_i,
   output logic                       ready_o,
   output logic [DW-1:0]              data_o  [VN],
   output logic                       valid_o [VN],
   input  logic                       ready_i [VN],
   output logic [$clog2(DEPTH):0]     count_o [VN],
   output logic                       err_o
);

   // Index width into one FIFO and pointer width including the wrap bit.
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   // True when exactly one bit of the tag is set.
   function automatic logic is_onehot(input logic [VN-1:0] v);
      return (v != '0) && ((v & (v - VN'(1))) == '0);
   endfunction

   logic          vc_onehot;
   logic [VN-1:0] full_vec;
   logic [VN-1:0] empty_vec;
   logic [VN-1:0] push_vec;
   logic [VN-1:0] pop_vec;

   assign vc_onehot = is_onehot(vc_i);

   // Link ready: a well-formed tag whose VC still has room. A full VC stays
   // not-ready even if it is being popped this cycle (no full-bypass), which
   // keeps this path purely vc_i -> full flags.
   assign ready_o = vc_onehot & ~|(vc_i & full_vec);

   genvar v;
   generate
      for (v = 0; v < VN; v++) begin : g_vc
         logic [PW-1:0] wptr;
         logic [PW-1:0] rptr;
         logic [DW-1:0] mem [DEPTH];

         assign empty_vec[v] = (wptr == rptr);
         assign full_vec[v]  = (wptr[AW-1:0] == rptr[AW-1:0]) &&
                               (wptr[AW] != rptr[AW]);

         // Only the tagged VC can take the flit; ready_o already guarantees
         // the tag is one-hot and that VC has space.
         assign push_vec[v] = valid_i & ready_o & vc_i[v];
         assign pop_vec[v]  = ~empty_vec[v] & ready_i[v];

         // Pointer update; reset discards buffered flits and wins over any
         // push or pop in the same cycle.
         always_ff @(posedge clk) begin
            if (rst) begin
               wptr <= '0;
               rptr <= '0;
            end else begin
               if (push_vec[v]) wptr <= wptr + PW'(1);
               if (pop_vec[v])  rptr <= rptr + PW'(1);
            end
         end

         // Flit storage; contents are never reset, only the pointers are.
         always_ff @(posedge clk) begin
            if (push_vec[v] && !rst) mem[wptr[AW-1:0]] <= data_i;
         end

         // Show-ahead head; meaningless when empty, but valid_o depends only
         // on the pointers so stale storage never leaks into it.
         assign data_o[v]  = mem[rptr[AW-1:0]];
         assign valid_o[v] = ~empty_vec[v];
         assign count_o[v] = wptr - rptr;
      end
   endgenerate

   // Sticky protocol error: a valid flit presented with a malformed tag.
   always_ff @(posedge clk) begin
      if (rst)                        err_o <= 1'b0;
      else if (valid_i && !vc_onehot) err_o <= 1'b1;
   end

endmodule

// File: tb/tb_cast_input_buffer.sv
// Bench for cast_input_buffer (DW=8, VN=2, DEPTH=4). The driver issues
// directed vectors and pushes accepted flits into per-VC expected queues;
// an independent monitor pops and compares whenever a VC head is consumed.
module tb_cast_input_buffer;
   localparam int DW    = 8;
   localparam int VN    = 2;
   localparam int DEPTH = 4;
   localparam int CW    = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic [VN-1:0] vc_i;
   logic [DW-1:0] data_i;
   logic          valid_i;
   logic          ready_o;
   logic [DW-1:0] data_o  [VN];
   logic          valid_o [VN];
   logic          ready_i [VN];
   logic [CW-1:0] count_o [VN];
   logic          err_o;

   always #5 clk = ~clk;

   cast_input_buffer #(.DW(DW), .VN(VN), .DEPTH(DEPTH)) dut (
      .clk     (clk),
      .rst     (rst),
      .vc_i    (vc_i),
      .data_i  (data_i),
      .valid_i (valid_i),
      .ready_o (ready_o),
      .data_o  (data_o),
      .valid_o (valid_o),
      .ready_i (ready_i),
      .count_o (count_o),
      .err_o   (err_o)
   );

   int            n_vec = 0;
   int            n_bad = 0;
   bit            chk_en = 1'b0;
   bit            merr = 1'b0;
   int            mcnt [VN];
   logic [DW-1:0] q0 [$];
   logic [DW-1:0] q1 [$];
   logic [DW-1:0] mon_exp;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock: check outputs against the model before the edge, advance
   // the model to what the edge should do, then return #1 after the edge.
   task automatic tick(output bit xfer);
      bit oh;
      int sel;
      bit er;
      bit pop [VN];
      @(negedge clk);
      oh  = $onehot(vc_i);
      sel = 0;
      for (int i = 0; i < VN; i++) if (vc_i[i]) sel = i;
      er = oh && (mcnt[sel] < DEPTH);
      if (chk_en) begin
         chk("ready_o", ready_o, er);
         for (int i = 0; i < VN; i++) begin
            chk($sformatf("valid_o%0d", i), valid_o[i], mcnt[i] != 0);
            chk($sformatf("count_o%0d", i), count_o[i], mcnt[i]);
         end
         chk("err_o", err_o, merr);
      end
      xfer = valid_i && er && !rst;
      if (rst) begin
         q0.delete();
         q1.delete();
         for (int i = 0; i < VN; i++) mcnt[i] = 0;
         merr = 1'b0;
      end else begin
         for (int i = 0; i < VN; i++) pop[i] = (mcnt[i] != 0) && ready_i[i];
         if (xfer) begin
            if (sel == 0) q0.push_back(data_i); else q1.push_back(data_i);
            mcnt[sel]++;
         end
         for (int i = 0; i < VN; i++) if (pop[i]) mcnt[i]--;
         if (valid_i && !oh) merr = 1'b1;
      end
      @(posedge clk);
      #1;
   endtask

   // Present a flit and hold it until it is accepted (bounded).
   task automatic send(input logic [VN-1:0] vc, input logic [DW-1:0] d);
      bit x;
      int guard;
      vc_i = vc; data_i = d; valid_i = 1'b1;
      x = 1'b0; guard = 0;
      while (!x && guard < 50) begin
         tick(x);
         guard++;
      end
      if (!x) begin
         n_vec++; n_bad++;
         $display("FAIL send_timeout: flit %0h on vc %b not accepted, expected acceptance", d, vc);
      end
      valid_i = 1'b0;
   endtask

   // Monitor: whenever a head is consumed this cycle, it must match the
   // oldest expected flit for that VC.
   always @(negedge clk) begin
      if (!rst && chk_en) begin
         for (int v = 0; v < VN; v++) begin
            if (valid_o[v] === 1'b1 && ready_i[v] === 1'b1) begin
               if ((v == 0) ? (q0.size() == 0) : (q1.size() == 0)) begin
                  n_vec++; n_bad++;
                  $display("FAIL head_underflow_vc%0d: got %0h, expected no flit", v, data_o[v]);
               end else begin
                  mon_exp = (v == 0) ? q0.pop_front() : q1.pop_front();
                  chk($sformatf("head_vc%0d", v), data_o[v], mon_exp);
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bit x;
      int idx;
      int guard;
      for (int i = 0; i < VN; i++) mcnt[i] = 0;
      rst = 1'b1; vc_i = 2'b01; data_i = '0; valid_i = 1'b0;
      ready_i[0] = 1'b0; ready_i[1] = 1'b0;

      // Reset then idle.
      tick(x);
      chk_en = 1'b1;
      tick(x);
      rst = 1'b0;
      tick(x);
      chk("idle_ready_vc01", ready_o, 1);

      // Fill VC0 with the core stalled.
      for (int i = 0; i < DEPTH; i++) begin
         send(2'b01, 8'hA0 + 8'(i));
         chk("fill_cnt0", count_o[0], i + 1);
      end
      vc_i = 2'b01; data_i = 8'hA4; valid_i = 1'b1;
      tick(x);
      chk("held_cnt0", count_o[0], 4);
      valid_i = 1'b0;
      chk("full_ready_vc01", ready_o, 0);
      vc_i = 2'b10;
      tick(x);
      chk("other_ready_vc10", ready_o, 1);

      // Full with simultaneous pop: pop only, then push+pop.
      vc_i = 2'b01; data_i = 8'hA4; valid_i = 1'b1; ready_i[0] = 1'b1;
      tick(x);
      chk("fullpop_cnt0", count_o[0], 3);
      tick(x);
      chk("pushpop_cnt0", count_o[0], 3);
      valid_i = 1'b0;
      repeat (3) tick(x);
      chk("drained_cnt0", count_o[0], 0);
      chk("drained_valid0", valid_o[0], 0);

      // Interleaved VCs, random core readiness, pointers wrap twice.
      idx = 0; guard = 0;
      while (idx < 20 && guard < 400) begin
         vc_i = (idx % 2 != 0) ? 2'b10 : 2'b01;
         data_i = 8'(idx);
         valid_i = 1'b1;
         ready_i[0] = 1'($urandom_range(0, 1));
         ready_i[1] = 1'($urandom_range(0, 1));
         tick(x);
         if (x) idx++;
         guard++;
      end
      chk("interleave_accepted", idx, 20);
      valid_i = 1'b0; ready_i[0] = 1'b1; ready_i[1] = 1'b1;
      repeat (6) tick(x);
      chk("interleave_cnt0", count_o[0], 0);
      chk("interleave_cnt1", count_o[1], 0);

      // Bad tag: multi-hot with valid, then zero tag without valid.
      ready_i[0] = 1'b0; ready_i[1] = 1'b0;
      vc_i = 2'b11; data_i = 8'hEE; valid_i = 1'b1;
      tick(x);
      chk("badtag_ready", ready_o, 0);
      chk("badtag_err", err_o, 1);
      chk("badtag_cnt0", count_o[0], 0);
      chk("badtag_cnt1", count_o[1], 0);
      vc_i = 2'b00; valid_i = 1'b0;
      tick(x);
      tick(x);
      chk("err_sticky", err_o, 1);

      // Reset mid-stream with a coinciding push.
      send(2'b10, 8'hB0);
      send(2'b10, 8'hB1);
      send(2'b10, 8'hB2);
      chk("pre_rst_cnt1", count_o[1], 3);
      rst = 1'b1; vc_i = 2'b10; data_i = 8'hBF; valid_i = 1'b1;
      tick(x);
      rst = 1'b0; valid_i = 1'b0;
      chk("rst_cnt1", count_o[1], 0);
      chk("rst_valid1", valid_o[1], 0);
      chk("rst_err", err_o, 0);
      send(2'b10, 8'hC0);
      ready_i[1] = 1'b1;
      repeat (3) tick(x);
      ready_i[1] = 1'b0;
      tick(x);

      chk("sb_empty", q0.size() + q1.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
